// File: rtl/fe_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: sizes, bubble encoding,
// FSM state encodings and widths of the AGEX->FE and FE->DE bundles.
package fe_fetch_stage_pkg;

    localparam int DBITS    = 32;
    localparam int INSTBITS = 32;

    localparam logic [DBITS-1:0]    START_PC = 32'h0000_0000;
    localparam logic [INSTBITS-1:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        FE_ST_FETCH = 2'd0,
        FE_ST_WAIT  = 2'd1,
        FE_ST_DROP  = 2'd2,
        FE_ST_HOLD  = 2'd3
    } fe_state_e;

    // {agex_br_taken, agex_pctarget}
    localparam int FROM_AGEX_TO_FE_WIDTH = 1 + DBITS;

    // {fe_valid, fe_inst, fe_pc, fe_pcplus, fe_inst_count}
    localparam int FE_LATCH_WIDTH = 1 + INSTBITS + 3 * DBITS;

endpackage

// File: rtl/fe_pc_gen.sv
// PC register for the fetch stage: +4 increment and redirect mux.
// Ports: clk, reset (async active-low), redirect/target in, inc in,
// pc / pc_plus4 out. Redirect targets are forced word aligned.
module fe_pc_gen #(
    parameter int               DBITS    = 32,
    parameter logic [DBITS-1:0] START_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [DBITS-1:0] target,
    input  logic             inc,
    output logic [DBITS-1:0] pc,
    output logic [DBITS-1:0] pc_plus4
);

    localparam logic [DBITS-1:0] ALIGN = ~DBITS'(3);

    assign pc_plus4 = pc + DBITS'(4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= START_PC & ALIGN;
        end else if (redirect) begin
            pc <= target & ALIGN;
        end else if (inc) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/fe_fetch_stage.sv
// Fetch stage: owns the PC, issues one imem read at a time, fills the
// FE latch read by DE, and squashes wrong-path fetches on an AGEX
// redirect. Ports: clk, reset (async active-low), imem_req_* /
// imem_addr (request), imem_rsp_* (response), agex_br_taken /
// agex_pctarget (redirect), de_stall (back-pressure), fe_* (latch).
// Optional macro FE_PERF_CNT_EN adds saturating perf_redirects,
// perf_squashed and perf_stall_cycles outputs.
module fe_fetch_stage #(
    parameter int DBITS    = fe_fetch_stage_pkg::DBITS,
    parameter int INSTBITS = fe_fetch_stage_pkg::INSTBITS,
    parameter logic [DBITS-1:0] START_PC =
        fe_fetch_stage_pkg::START_PC,
    parameter logic [INSTBITS-1:0] NOP_INST =
        fe_fetch_stage_pkg::NOP_INST
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [DBITS-1:0]    imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTBITS-1:0] imem_rsp_data,
    input  logic                agex_br_taken,
    input  logic [DBITS-1:0]    agex_pctarget,
    input  logic                de_stall,
    output logic                fe_valid,
    output logic [INSTBITS-1:0] fe_inst,
    output logic [DBITS-1:0]    fe_pc,
    output logic [DBITS-1:0]    fe_pcplus,
    output logic [DBITS-1:0]    fe_inst_count
`ifdef FE_PERF_CNT_EN
    ,
    output logic [DBITS-1:0]    perf_redirects,
    output logic [DBITS-1:0]    perf_squashed,
    output logic [DBITS-1:0]    perf_stall_cycles
`endif
);

    import fe_fetch_stage_pkg::*;

    fe_state_e state, state_nxt;

    logic [DBITS-1:0]    pc;
    logic [DBITS-1:0]    pc_plus4;
    logic [DBITS-1:0]    inst_cnt;
    logic [INSTBITS-1:0] skid;
    logic [INSTBITS-1:0] ld_data;

    logic req_fetch;
    logic latch_free;
    logic ld_rsp;
    logic ld_skid;
    logic to_skid;
    logic load;

    assign latch_free = !fe_valid || !de_stall;
    assign load       = ld_rsp || ld_skid;
    assign ld_data    = ld_skid ? skid : imem_rsp_data;

    // State sits in FETCH during reset; keep the request quiet
    // until reset is released.
    assign imem_req_valid = req_fetch && reset;
    assign imem_addr      = pc;

    fe_pc_gen #(
        .DBITS    (DBITS),
        .START_PC (START_PC)
    ) u_pc_gen (
        .clk      (clk),
        .reset    (reset),
        .redirect (agex_br_taken),
        .target   (agex_pctarget),
        .inc      (load),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FE_ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FE_ST_FETCH: begin
                if (imem_req_ready) begin
                    state_nxt = agex_br_taken ? FE_ST_DROP
                                              : FE_ST_WAIT;
                end
            end
            FE_ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (agex_br_taken || latch_free) begin
                        state_nxt = FE_ST_FETCH;
                    end else begin
                        state_nxt = FE_ST_HOLD;
                    end
                end else if (agex_br_taken) begin
                    state_nxt = FE_ST_DROP;
                end
            end
            FE_ST_HOLD: begin
                if (agex_br_taken || latch_free) begin
                    state_nxt = FE_ST_FETCH;
                end
            end
            FE_ST_DROP: begin
                if (imem_rsp_valid) begin
                    state_nxt = FE_ST_FETCH;
                end
            end
        endcase
    end

    always_comb begin
        req_fetch = 1'b0;
        ld_rsp    = 1'b0;
        ld_skid   = 1'b0;
        to_skid   = 1'b0;
        unique case (state)
            FE_ST_FETCH: req_fetch = 1'b1;
            FE_ST_WAIT: begin
                if (imem_rsp_valid && !agex_br_taken) begin
                    ld_rsp  = latch_free;
                    to_skid = !latch_free;
                end
            end
            FE_ST_HOLD: ld_skid = !agex_br_taken && latch_free;
            FE_ST_DROP: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid <= NOP_INST;
        end else if (agex_br_taken) begin
            skid <= NOP_INST;
        end else if (to_skid) begin
            skid <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fe_valid      <= 1'b0;
            fe_inst       <= NOP_INST;
            fe_pc         <= '0;
            fe_pcplus     <= '0;
            fe_inst_count <= '0;
            inst_cnt      <= '0;
        end else if (agex_br_taken) begin
            fe_valid <= 1'b0;
            fe_inst  <= NOP_INST;
        end else if (load) begin
            fe_valid      <= 1'b1;
            fe_inst       <= ld_data;
            fe_pc         <= pc;
            fe_pcplus     <= pc_plus4;
            fe_inst_count <= inst_cnt;
            inst_cnt      <= inst_cnt + DBITS'(1);
        end else if (fe_valid && !de_stall) begin
            fe_valid <= 1'b0;
            fe_inst  <= NOP_INST;
        end
    end

`ifdef FE_PERF_CNT_EN
    logic       drop_rsp;
    logic [1:0] squash_inc;

    // A response is thrown away in DROP, or in WAIT when a
    // redirect lands in the same cycle.
    assign drop_rsp = imem_rsp_valid &&
        ((state == FE_ST_WAIT && agex_br_taken) ||
         state == FE_ST_DROP);

    assign squash_inc = {1'b0, drop_rsp} +
                        {1'b0, agex_br_taken && fe_valid};

    function automatic logic [DBITS-1:0] sat_add(
        input logic [DBITS-1:0] a,
        input logic [1:0]       b
    );
        logic [DBITS:0] s;
        s = {1'b0, a} + {{(DBITS-1){1'b0}}, b};
        return s[DBITS] ? '1 : s[DBITS-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_redirects    <= '0;
            perf_squashed     <= '0;
            perf_stall_cycles <= '0;
        end else begin
            perf_redirects <= sat_add(perf_redirects,
                                      {1'b0, agex_br_taken});
            perf_squashed  <= sat_add(perf_squashed, squash_inc);
            perf_stall_cycles <= sat_add(perf_stall_cycles,
                                   {1'b0, de_stall && fe_valid});
        end
    end
`endif

endmodule

// File: tb/tb_fe_fetch_stage.sv
// Bench for fe_fetch_stage: directed scenarios plus random traffic
// checked against a transaction-level model of the fetch stream.
module tb_fe_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] SPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        agex_br_taken = 1'b0;
    logic [31:0] agex_pctarget = '0;
    logic        de_stall = 1'b0;
    logic        fe_valid;
    logic [31:0] fe_inst;
    logic [31:0] fe_pc;
    logic [31:0] fe_pcplus;
    logic [31:0] fe_inst_count;
`ifdef FE_PERF_CNT_EN
    logic [31:0] perf_redirects;
    logic [31:0] perf_squashed;
    logic [31:0] perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    fe_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .agex_br_taken  (agex_br_taken),
        .agex_pctarget  (agex_pctarget),
        .de_stall       (de_stall),
        .fe_valid       (fe_valid),
        .fe_inst        (fe_inst),
        .fe_pc          (fe_pc),
        .fe_pcplus      (fe_pcplus),
        .fe_inst_count  (fe_inst_count)
`ifdef FE_PERF_CNT_EN
        ,
        .perf_redirects    (perf_redirects),
        .perf_squashed     (perf_squashed),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model of the fetch stream.
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    int          loads;
    // Memory model: one pending read.
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    int          lat_lo;
    int          lat_hi;
    logic        stray;
    // Request stability tracking.
    logic        last_hold;
    logic [31:0] last_addr;
    // Per-step observations.
    logic        pre_req;
    logic        pre_acc;
    logic [31:0] pre_addr;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ a;
    endfunction

    task automatic drv(input logic rdy, input logic st,
                       input logic br, input logic [31:0] tgt);
        imem_req_ready = rdy;
        de_stall       = st;
        agex_br_taken  = br;
        agex_pctarget  = tgt;
    endtask

    // Called at posedge+1; runs one clock and checks the result.
    task automatic step();
        logic        p_fv, p_st, p_br, p_rv, p_rdy;
        logic [31:0] p_inst, p_pc, p_pcp, p_cnt, p_tgt;
        imem_rsp_valid = stray || (pend && pend_cnt == 0);
        imem_rsp_data  = stray ? 32'hDEAD_BEEF
                               : mem_word(pend_addr);
        @(negedge clk);
        pre_req  = imem_req_valid;
        pre_addr = imem_addr;
        pre_acc  = imem_req_valid && imem_req_ready;
        if (last_hold) begin
            chk("req_hold_valid", imem_req_valid, 1);
            chk("req_hold_addr", imem_addr, last_addr);
        end
        if (pre_acc) begin
            chk("req_addr", imem_addr, exp_pc);
        end
        p_fv = fe_valid;    p_inst = fe_inst;
        p_pc = fe_pc;       p_pcp = fe_pcplus;
        p_cnt = fe_inst_count;
        p_st = de_stall;    p_br = agex_br_taken;
        p_tgt = agex_pctarget;
        p_rv = imem_rsp_valid;
        p_rdy = imem_req_ready;
        @(posedge clk);
        #1;
        if (p_br) begin
            chk("redir_valid", fe_valid, 0);
            chk("redir_inst", fe_inst, NOP);
        end else if (p_fv && p_st) begin
            chk("frz_valid", fe_valid, 1);
            chk("frz_inst", fe_inst, p_inst);
            chk("frz_pc", {fe_pc, fe_pcplus}, {p_pc, p_pcp});
            chk("frz_cnt", fe_inst_count, p_cnt);
        end else if (fe_valid) begin
            chk("ld_pc", fe_pc, exp_pc);
            chk("ld_inst", fe_inst, mem_word(exp_pc));
            chk("ld_pcplus", fe_pcplus, exp_pc + 32'd4);
            chk("ld_cnt", fe_inst_count, exp_cnt);
            exp_pc  = exp_pc + 32'd4;
            exp_cnt = exp_cnt + 32'd1;
            loads++;
        end else begin
            chk("bubble_inst", fe_inst, NOP);
        end
        if (p_br) exp_pc = p_tgt & ~32'h3;
        last_hold = pre_req && !p_rdy && !p_br;
        last_addr = pre_addr;
        if (p_rv && !stray) pend = 1'b0;
        if (pre_acc) begin
            pend      = 1'b1;
            pend_addr = pre_addr;
            pend_cnt  = $urandom_range(lat_hi, lat_lo);
        end else if (pend && pend_cnt > 0) begin
            pend_cnt--;
        end
    endtask

    // Holds reset for two edges, checks reset values, releases it
    // at a negedge and returns at posedge+1.
    task automatic do_reset();
        reset = 1'b0;
        drv(0, 0, 0, 32'h0);
        stray          = 1'b0;
        imem_rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", fe_valid, 0);
        chk("rst_inst", fe_inst, NOP);
        chk("rst_pc", fe_pc, 0);
        chk("rst_pcplus", fe_pcplus, 0);
        chk("rst_cnt", fe_inst_count, 0);
        chk("rst_req", imem_req_valid, 0);
`ifdef FE_PERF_CNT_EN
        chk("rst_perf_redir", perf_redirects, 0);
        chk("rst_perf_squash", perf_squashed, 0);
        chk("rst_perf_stall", perf_stall_cycles, 0);
`endif
        exp_pc    = SPC;
        exp_cnt   = '0;
        pend      = 1'b0;
        pend_cnt  = 0;
        pend_addr = '0;
        last_hold = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st_left;
        int n;
        loads  = 0;
        lat_lo = 0;
        lat_hi = 0;
        do_reset();

        // Zero-wait memory: one load every two cycles.
        drv(1, 0, 0, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("zw_valid", fe_valid, (k % 2) == 0);
            if (k % 2 == 0) begin
                chk("zw_pc", fe_pc, 32'(4 * (k / 2 - 1)));
                chk("zw_cnt", fe_inst_count, 32'(k / 2 - 1));
            end
        end

        // Stall with fe_pc=0x8: skid fills, requests stop.
        drv(1, 1, 0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            if (i >= 2) chk("hold_no_req", pre_req, 0);
        end
        drv(1, 0, 0, 32'h0);
        step();
        chk("skid_pc", fe_pc, 32'hC);

        // Redirect while waiting on a slow fetch of 0x10.
        lat_lo = 2;
        lat_hi = 2;
        step();
        chk("slow_addr", pre_addr, 32'h10);
        drv(1, 0, 1, 32'h100);
        step();
        chk("wait_redir_valid", fe_valid, 0);
        drv(1, 0, 0, 32'h0);
        step();
        step();
        lat_lo = 0;
        lat_hi = 0;
        step();
        chk("after_drop_addr", pre_addr, 32'h100);
        step();

        // Redirect coincident with response under stall.
        drv(1, 1, 0, 32'h0);
        step();
        drv(1, 1, 1, 32'h100);
        step();
        chk("coinc_valid", fe_valid, 0);
        drv(0, 0, 0, 32'h0);
        step();
        chk("coinc_req", pre_req, 1);
        chk("coinc_addr", pre_addr, 32'h100);

        // Unaligned target.
        drv(0, 0, 1, 32'h203);
        step();
        drv(0, 0, 0, 32'h0);
        step();
        chk("align_addr", pre_addr, 32'h200);

        // Random traffic.
        lat_lo  = 0;
        lat_hi  = 3;
        st_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (st_left > 0) begin
                st_left--;
            end else if ($urandom_range(99, 0) < 15) begin
                st_left = $urandom_range(6, 1);
            end
            drv($urandom_range(99, 0) < 70, st_left > 0,
                $urandom_range(99, 0) < 6,
                $urandom & 32'h0000_0FFF);
            step();
        end

        // Reset while a slow fetch is outstanding.
        lat_lo = 3;
        lat_hi = 3;
        drv(1, 0, 0, 32'h0);
        n = 0;
        do begin
            step();
            n++;
        end while (!pre_acc && n < 20);
        chk("reach_wait", pre_acc, 1);
        do_reset();
        stray = 1'b1;
        drv(0, 0, 0, 32'h0);
        step();
        stray = 1'b0;
        chk("stray_valid", fe_valid, 0);
        chk("first_req", pre_req, 1);
        chk("first_addr", pre_addr, SPC);
        lat_lo = 0;
        lat_hi = 2;
        for (int c = 0; c < 60; c++) begin
            drv($urandom_range(99, 0) < 80,
                $urandom_range(99, 0) < 20, 1'b0, 32'h0);
            step();
        end
        chk("progress", loads >= 200, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_cnt, err_cnt);
        $finish;
    end

endmodule
